zion_riscv_isa_lib_int_issue: RTL
=================================

ZION_RISCV_ISA_LIB_INT_ISSUE -- requirements
Module: zion_riscv_isa_lib_int_issue

Interface
REQ-001 Parameter: RV64, 0, 1 selects RV64I; CPU_WIDTH = 32*(RV64+1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 deVld  input  1  decode offers an instruction.
REQ-005 deRdy  output  1  stage can accept; registered, high when skid entry empty.
REQ-006 deDat  input  payload_t  decoded instruction: pc, s1, s2, offset, flags, enables (add/sub/and/or/xor/slt/sft/bj/branch/beq/bne/blt/bge/jump/mem/addSubIns), linkOffset, rdIdx, rdWrEn.
REQ-007 deRs1Idx, deRs2Idx  input  5 each  source register indices.
REQ-008 deUseRs1, deUseRs2  input  1 each  s1/s2 come from register file (else immediate/pc; no forwarding).
REQ-009 wbWrEn  input  1; wbIdx  input  5; wbDat  input  CPU_WIDTH: writeback snoop port.
REQ-010 flush  input  1  branch/jump taken (BjEn != 0) in execute; kill everything held.
REQ-011 exVld  output  1  head entry valid toward integer execute.
REQ-012 exRdy  input  1  integer execute consumes head.
REQ-013 exDat  output  payload_t  head payload with forwarded s1/s2, drives IntEx input fields directly.

Function
REQ-014 Storage SHALL be two entries: head (drives exDat) and skid; occupancy 0, 1 or 2.
REQ-015 Accept SHALL occur when deVld & deRdy & !flush; consume when exVld & exRdy.
REQ-016 Occupancy 0: accept loads head; exVld high next cycle (latency 1).
REQ-017 Occupancy 1: accept without consume loads skid, deRdy low next cycle; accept with consume loads head, occupancy stays 1.
REQ-018 Occupancy 2: consume moves skid to head, deRdy high next cycle; no accept possible.
REQ-019 Consume without accept SHALL decrement occupancy; at 0, exVld low.
REQ-020 exDat SHALL hold stable while exVld & !exRdy.
REQ-021 Forwarding at accept: if deUseRsN & wbWrEn & wbIdx==deRsNIdx & wbIdx!=0, captured sN = wbDat.
REQ-022 Snoop while held: each cycle, every valid entry with useRsN & wbWrEn & wbIdx==rsNIdx & wbIdx!=0 SHALL replace its sN with wbDat, including the entry moving skid->head that cycle.
REQ-023 Index 0 SHALL never be forwarded; s1 and s2 matching same wbIdx both update.
REQ-024 flush SHALL clear occupancy to 0 next cycle, drop any same-cycle deVld, override consume; deRdy high next cycle.
REQ-025 exDat contents when exVld low are don't-care but SHALL not be X after reset (zeroed).

Reset
REQ-026 On rst assertion, immediately: occupancy 0, exVld 0, deRdy 1, both entries' payload 0.
REQ-027 rst mid-transfer SHALL discard held instructions; first accept after deassertion behaves as REQ-016.

Structure
REQ-028 Package ZionRiscvIsaLib_IntIssuePkg SHALL hold payload_t (packed struct parameterised via RV64 width macro), CPU_WIDTH function, and occupancy encoding constants.
REQ-029 One sub-module zion_riscv_isa_lib_opd_snoop SHALL implement match-and-replace for one operand; instantiated per entry per operand (4 instances).
REQ-030 Control is a 3-state FSM: EMPTY, ONE, FULL; no other state.

Verification
REQ-031 Stream: deVld held high, exRdy=1, 4 instructions pc 0x0,4,8,C -> exVld from cycle 1, one per cycle, in order, deRdy never low.
REQ-032 Backpressure: exRdy=0, offer pc 0x10,0x14,0x18 -> 0x10,0x14 accepted, deRdy low after 2nd, 0x18 held; exRdy=1 -> order 0x10,0x14,0x18, no loss/dup.
REQ-033 Forward: head rs1=5, useRs1=1, s1=0x1111, exRdy=0; wbWrEn=1,wbIdx=5,wbDat=0xABCD -> next cycle exDat.s1=0xABCD.
REQ-034 x0: useRs2=1, rs2=0, wbIdx=0, wbDat=0xFFFF -> s2 unchanged; useRs1=0 with matching idx -> s1 unchanged.
REQ-035 Flush: occupancy 2, flush=1 with deVld=1 -> next cycle exVld=0, deRdy=1, offered instruction not issued.
REQ-036 Reset: rst pulsed asynchronously while occupancy 2 -> exVld=0, deRdy=1 before next clock edge; exDat=0.

Source files
------------

// File: rtl/ZionRiscvIsaLib_IntIssuePkg.sv
// Shared types for the integer issue stage: decoded payload, held entry and
// occupancy encoding. Operand width follows ZION_RV64 (0 = RV32I, 1 = RV64I).
`ifndef ZION_RV64
`define ZION_RV64 0
`endif

package ZionRiscvIsaLib_IntIssuePkg;

  localparam int RV64_DEF = `ZION_RV64;

  function automatic int cpuWidth(input int rv64);
    return 32 * (rv64 + 1);
  endfunction

  localparam int XLEN = cpuWidth(RV64_DEF);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = OCC_EMPTY,
    ONE   = OCC_ONE,
    FULL  = OCC_FULL
  } occ_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic [XLEN-1:0] offset;
    logic [3:0]      flags;
    logic            addEn;
    logic            subEn;
    logic            andEn;
    logic            orEn;
    logic            xorEn;
    logic            sltEn;
    logic            sftEn;
    logic            bjEn;
    logic            branchEn;
    logic            beqEn;
    logic            bneEn;
    logic            bltEn;
    logic            bgeEn;
    logic            jumpEn;
    logic            memEn;
    logic            addSubIns;
    logic [XLEN-1:0] linkOffset;
    logic [4:0]      rdIdx;
    logic            rdWrEn;
  } payload_t;

  // Source indices and use flags travel with the payload so held entries can snoop.
  typedef struct packed {
    payload_t   payload;
    logic [4:0] rs1Idx;
    logic [4:0] rs2Idx;
    logic       useRs1;
    logic       useRs2;
  } entry_t;

endpackage

// File: rtl/zion_riscv_isa_lib_opd_snoop.sv
// Single-operand writeback match: replaces the operand with the writeback data
// when the operand is register-sourced and the (non-x0) index matches.
module zion_riscv_isa_lib_opd_snoop #(
  parameter int W = 32
) (
  input  logic         useRs,
  input  logic [4:0]   rsIdx,
  input  logic         wbWrEn,
  input  logic [4:0]   wbIdx,
  input  logic [W-1:0] wbDat,
  input  logic [W-1:0] opdIn,
  output logic [W-1:0] opdOut
);

  logic hit;

  assign hit    = useRs & wbWrEn & (wbIdx == rsIdx) & (wbIdx != 5'd0);
  assign opdOut = hit ? wbDat : opdIn;

endmodule

// File: rtl/zion_riscv_isa_lib_int_issue.sv
// Two-entry (head + skid) issue buffer between decode and integer execute,
// with writeback forwarding at accept and continuous snooping while held.
module zion_riscv_isa_lib_int_issue
  import ZionRiscvIsaLib_IntIssuePkg::*;
#(
  parameter  int RV64      = RV64_DEF,
  localparam int CPU_WIDTH = cpuWidth(RV64)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 deVld,
  output logic                 deRdy,
  input  payload_t             deDat,
  input  logic [4:0]           deRs1Idx,
  input  logic [4:0]           deRs2Idx,
  input  logic                 deUseRs1,
  input  logic                 deUseRs2,
  input  logic                 wbWrEn,
  input  logic [4:0]           wbIdx,
  input  logic [CPU_WIDTH-1:0] wbDat,
  input  logic                 flush,
  output logic                 exVld,
  input  logic                 exRdy,
  output payload_t             exDat
);

  occ_e             state, stateNext;
  logic             deRdyReg, exVldReg;
  entry_t [1:0]     entryReg, entrySrc, entryNext;
  entry_t           deEntry;
  logic             loadHeadDe, loadHeadSkid, loadSkidDe;
  logic             accept, consume;
  logic [CPU_WIDTH-1:0] fwdS1 [2];
  logic [CPU_WIDTH-1:0] fwdS2 [2];

  assign accept  = deVld & deRdyReg & ~flush;
  assign consume = exVldReg & exRdy;
  assign deEntry = '{payload: deDat, rs1Idx: deRs1Idx, rs2Idx: deRs2Idx,
                     useRs1: deUseRs1, useRs2: deUseRs2};

  always_comb begin
    stateNext    = state;
    loadHeadDe   = 1'b0;
    loadHeadSkid = 1'b0;
    loadSkidDe   = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        stateNext  = ONE;
        loadHeadDe = 1'b1;
      end
      ONE: begin
        if (accept && consume) begin
          loadHeadDe = 1'b1;
        end else if (accept) begin
          stateNext  = FULL;
          loadSkidDe = 1'b1;
        end else if (consume) begin
          stateNext = EMPTY;
        end
      end
      FULL: if (consume) begin
        stateNext    = ONE;
        loadHeadSkid = 1'b1;
      end
      default: stateNext = EMPTY;
    endcase
    if (flush) stateNext = EMPTY;
  end

  // Select what each slot holds next cycle; snooping then runs on that source,
  // so accept-time forwarding and skid->head moves share the same matchers.
  always_comb begin
    entrySrc = entryReg;
    if (loadHeadDe)        entrySrc[0] = deEntry;
    else if (loadHeadSkid) entrySrc[0] = entryReg[1];
    if (loadSkidDe)        entrySrc[1] = deEntry;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gSnoop
    zion_riscv_isa_lib_opd_snoop #(.W(CPU_WIDTH)) uSnoopS1 (
      .useRs  (entrySrc[gi].useRs1),
      .rsIdx  (entrySrc[gi].rs1Idx),
      .wbWrEn (wbWrEn),
      .wbIdx  (wbIdx),
      .wbDat  (wbDat),
      .opdIn  (entrySrc[gi].payload.s1),
      .opdOut (fwdS1[gi])
    );
    zion_riscv_isa_lib_opd_snoop #(.W(CPU_WIDTH)) uSnoopS2 (
      .useRs  (entrySrc[gi].useRs2),
      .rsIdx  (entrySrc[gi].rs2Idx),
      .wbWrEn (wbWrEn),
      .wbIdx  (wbIdx),
      .wbDat  (wbDat),
      .opdIn  (entrySrc[gi].payload.s2),
      .opdOut (fwdS2[gi])
    );
  end

  always_comb begin
    entryNext = entrySrc;
    for (int i = 0; i < 2; i++) begin
      entryNext[i].payload.s1 = fwdS1[i];
      entryNext[i].payload.s2 = fwdS2[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deRdyReg <= 1'b1;
      exVldReg <= 1'b0;
      entryReg <= '0;
    end else begin
      deRdyReg <= (stateNext != FULL);
      exVldReg <= (stateNext != EMPTY);
      entryReg <= entryNext;
    end
  end

  assign deRdy = deRdyReg;
  assign exVld = exVldReg;
  assign exDat = entryReg[0].payload;

endmodule
